// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

  // Controller states: load in IDLE, one restoring step per RUN cycle,
  // sign correction in FIX, result held in DONE until consumed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width of a counter that must be able to hold the value w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, restore on borrow.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register it.
//
// Ports:
//   rem_in   (WIDTH+1) partial remainder before this step
//   din      next dividend bit, MSB first
//   divisor  (WIDTH)   divisor magnitude
//   rem_out  (WIDTH+1) partial remainder after this step
//   q_bit    quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             din,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic             borrow;
  logic [WIDTH:0]   diff;

  // The shifted remainder is below 2*divisor, so its top bit is always zero
  // and the MSB of this (WIDTH+2)-bit difference is exactly the borrow.
  assign {borrow, diff} = {rem_in, din} - {2'b00, divisor};

  assign rem_out = borrow ? {rem_in[WIDTH-1:0], din} : diff;
  assign q_bit   = ~borrow;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (unsigned or two's-complement) with divide-by-zero detection.
// Latency: WIDTH+2 edges counting the acceptance edge (load, WIDTH steps, fix); 1 edge for b == 0.
// Backpressure: result held in DONE while out_ready is low; no new operands accepted until consumed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   sign_en, a, b         signed-mode select, dividend, divisor (sampled at acceptance)
//   out_valid / out_ready result handshake (out_valid only in DONE)
//   q, r, div_by_zero     registered quotient, remainder, zero-divisor flag
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH:0]   prem_nxt;
  // Holds the dividend magnitude; quotient bits shift in from the LSB as
  // dividend bits leave from the MSB, so after WIDTH steps it is the quotient.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
  logic             q_bit;

  logic             b_zero;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    b_zero = (b == '0);
    a_neg  = sign_en & a[WIDTH-1];
    b_neg  = sign_en & b[WIDTH-1];
    // -(most negative) wraps to itself, which is the correct unsigned magnitude.
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem),
    .din     (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = b_zero ? DONE : RUN;
      RUN:  if (cnt == LAST_STEP) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      prem        <= '0;
      dvd         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      q           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (b_zero) begin
              q           <= '1;
              r           <= a;
              div_by_zero <= 1'b1;
            end else begin
              dvd   <= a_mag;
              dvs   <= b_mag;
              q_neg <= a_neg ^ b_neg;
              r_neg <= a_neg;
              cnt   <= '0;
              prem  <= '0;
            end
          end
        end
        RUN: begin
          prem <= prem_nxt;
          dvd  <= {dvd[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          // Truncation toward zero; remainder follows the dividend's sign.
          q           <= q_neg ? -dvd : dvd;
          r           <= r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle restoring divider: the sequential successor of the 4-bit combinational divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor using one shared subtract/restore stage that runs once per clock instead of an unrolled chain. It adds a signed mode, divide-by-zero detection and a valid/ready handshake on both sides. It sits in the datapath as a long-latency arithmetic unit with the same quotient/remainder semantics as the combinational divider.

## Interface
- WIDTH, 8: operand, quotient and remainder width; legal range ≥2.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- sign_en  in  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- q  out  WIDTH  quotient.
- r  out  WIDTH  remainder.
- div_by_zero  out  1  result came from b == 0.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE: in_ready = 1. Acceptance happens on the edge where in_valid && in_ready.
  - b == 0: go to DONE; q = all ones, r = a (raw bits), div_by_zero = 1.
  - Otherwise: latch magnitudes |a| and |b| (the raw value when sign_en = 0), quotient sign (a_msb ^ b_msb) & sign_en, and remainder sign a_msb & sign_en. Clear step counter and partial remainder, then go to RUN.
- RUN: each edge performs one restoring step, MSB first.
  - Shift the next dividend bit into the (WIDTH+1)-bit partial remainder, then trial-subtract |b|.
  - No borrow: keep the difference and set the quotient bit to 1.
  - Borrow: restore the shifted value and set the quotient bit to 0.
  - After WIDTH steps, go to FIX.
- FIX: negate q if the quotient sign is set and negate r if the remainder sign is set. Division truncates toward zero and the remainder takes the dividend's sign. Go to DONE.
- DONE: out_valid = 1. q, r and div_by_zero stay stable until out_valid && out_ready, then the block returns to IDLE.
- in_ready = 0 in RUN, FIX and DONE. No new operand is accepted on the same edge a result is consumed.
- Signed overflow (most negative value / -1): q = most negative value, r = 0. This is natural wrap and no flag is raised.
- Unsigned mode is bit-exact with the combinational divider for WIDTH = 4.

## Timing
- Reset (asynchronous, rst_n low): state = IDLE, in_ready = 1, out_valid = 0, q = 0, r = 0, div_by_zero = 0, all internal registers cleared.
- Reset asserted mid-operation aborts immediately and discards the operation, with no result emitted.
- Normal latency: out_valid rises WIDTH+2 edges after the acceptance edge (1 load, WIDTH RUN, 1 FIX).
- Divide by zero: out_valid rises on the edge after acceptance (1 cycle).
- Throughput: at most one operation per WIDTH+3 cycles when out_ready is held high.
- q, r and div_by_zero are registered outputs and change only on the edge entering DONE (or on reset).
- in_ready and out_valid are decoded directly from the state register, with no combinational path from the inputs.
- out_ready, when low, holds DONE indefinitely, with no timeout.

## Structure
- Package div_pkg: state enum (IDLE, RUN, FIX, DONE), default WIDTH constant, counter-width function $clog2(WIDTH+1).
- Sub-module div_step, purely combinational:
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - It is the parametrised subtract+restore stage and is instantiated once.
- Top seq_divider contains the FSM, step counter, operand/sign registers and FIX negation.

## Test plan
- WIDTH=8, unsigned 13/3 -> q=0x04, r=0x01, div_by_zero=0, out_valid exactly 10 edges after acceptance.
- WIDTH=8, signed -7/2 (a=0xF9, b=0x02) -> q=0xFD (-3), r=0xFF (-1); also 7/-2 -> q=0xFD, r=0x01.
- WIDTH=8, 200/0 unsigned -> q=0xFF, r=0xC8, div_by_zero=1, out_valid 1 edge after acceptance.
- WIDTH=8, signed 0x80/0xFF -> q=0x80, r=0x00, div_by_zero=0. Unsigned 0x80/0xFF -> q=0x00, r=0x80.
- Backpressure: hold out_ready low 5 cycles in DONE -> q/r stable, in_ready=0, an in_valid pulse is ignored. Release -> one handshake, then in_ready=1 next cycle.
- Reset mid-RUN (step 3 of 8) -> all outputs zero, in_ready=1 immediately. The next operation 255/16 unsigned -> q=0x0F, r=0x0F. Sweep all 4-bit unsigned pairs with WIDTH=4 against a reference model.
